// File: rtl/axis_uart_tx.sv
// axis_uart_tx: buffered 8N1 UART transmitter fed by a non-backpressuring byte strobe.
// Bytes queue in a circular FIFO; overflowing bytes are dropped and flagged.
module axis_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          overflow_clr,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d, tx_q, tx_d;
    logic             baud_end, has_data, pop, push, drop;

    assign baud_end  = baud_q == CW'(CLKS_PER_BIT - 1);
    assign has_data  = count_q != '0;
    assign fifo_full = count_q == (AW + 1)'(FIFO_DEPTH);
    // A pop frees a slot in the same cycle, so a push to a full FIFO survives it
    assign pop       = has_data && (state_q == IDLE || (state_q == STOP && baud_end));
    assign push      = in_valid && (!fifo_full || pop);
    assign drop      = in_valid && !push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (has_data) state_d = START;
            START:   if (baud_end) state_d = DATA;
            DATA:    if (baud_end && bit_q == BW'(WIDTH - 1)) state_d = STOP;
            STOP:    if (baud_end) state_d = has_data ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        baud_d  = (state_d != state_q || baud_end || state_q == IDLE) ? '0 : baud_q + 1'b1;
        bit_d   = (state_q != DATA) ? '0 : baud_end ? bit_q + 1'b1 : bit_q;
        shift_d = pop ? mem_q[rd_q] : (state_q == DATA && baud_end) ? shift_q >> 1 : shift_q;
        count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
        ovf_d   = drop || (ovf_q && !overflow_clr);
    end

    // tx is registered from the next state so the line moves on the same edge as the FSM
    always_comb begin
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= push ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop ? rd_q + 1'b1 : rd_q;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data;
    end

    assign tx         = tx_q;
    assign busy       = state_q != IDLE;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: directed stimulus with a scoreboard of expected bytes checked by a UART line monitor.
module tb_axis_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       overflow_clr = 1'b0;
    logic       tx, busy, fifo_full, overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    axis_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .overflow_clr(overflow_clr), .tx(tx), .busy(busy), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: decode frames from the line, sampling mid-bit, and compare with the scoreboard
    int         mcnt = 0;
    bit         mact = 0;
    logic [7:0] mbyte = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) mact = 0;
        else if (!mact) begin
            if (tx === 1'b0) begin
                mact = 1;
                mcnt = 0;
                starts.push_back(cyc);
            end
        end else begin
            mcnt++;
            if (mcnt % CPB == 2 && mcnt >= 6 && mcnt <= 34) mbyte[(mcnt - 6) / CPB] = tx;
            if (mcnt == 38) begin
                chk("stop_bit", {31'b0, tx}, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %02h expected no frame", mbyte);
                end else chk("frame_byte", {24'b0, mbyte}, {24'b0, exp_q.pop_front()});
                mact = 0;
            end
        end
    end

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && fifo_count == 0 && exp_q.size() == 0) break;
        end
        chk({name, "_drain"}, (i < 3000) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] hello [6] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
    logic [7:0] nine  [9] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h7E};
    int n, peak, k0, target;

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx", {31'b0, tx}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_full", {31'b0, fifo_full}, 0);
        chk("rst_count", {29'b0, fifo_count}, 0);
        chk("rst_ovf", {31'b0, overflow}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single frame 0x48: latency and busy duration
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h48; exp_q.push_back(8'h48);
        @(posedge clk); #1;
        chk("t1_count_capture", {29'b0, fifo_count}, 1);
        chk("t1_tx_before", {31'b0, tx}, 1);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t1_tx_fall", {31'b0, tx}, 0);
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_count_pop", {29'b0, fifo_count}, 0);
        n = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("t1_busy_cycles", n, 40);
        wait_idle("t1");

        // HELLO\n on consecutive cycles: '\n' dropped, frames back-to-back
        starts.delete();
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (32'(fifo_count) > peak) peak = 32'(fifo_count);
            in_valid = 1'b1; in_data = hello[i];
            if (i < 5) exp_q.push_back(hello[i]);
        end
        @(negedge clk); in_valid = 1'b0;
        chk("t2_peak", peak, 4);
        chk("t2_ovf", {31'b0, overflow}, 1);
        chk("t2_count", {29'b0, fifo_count}, 4);
        chk("t2_full", {31'b0, fifo_full}, 1);
        wait_idle("t2");
        chk("t2_frames", starts.size(), 5);
        for (int i = 1; i < starts.size(); i++) chk("t2_gap", starts[i] - starts[i-1], 40);
        chk("t2_ovf_sticky", {31'b0, overflow}, 1);

        // overflow clear, then clear coinciding with a drop, then push on STOP-end pop
        @(negedge clk); overflow_clr = 1'b1;
        @(posedge clk); #1;
        chk("t3_clr", {31'b0, overflow}, 0);
        @(negedge clk); overflow_clr = 1'b0;
        k0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) k0 = cyc;
            in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
            if (i == 5) overflow_clr = 1'b1;
            else exp_q.push_back(8'hA0 + 8'(i));
        end
        @(negedge clk); in_valid = 1'b0; overflow_clr = 1'b0;
        chk("t3_drop_beats_clr", {31'b0, overflow}, 1);
        chk("t3_count_full", {29'b0, fifo_count}, 4);
        @(negedge clk); overflow_clr = 1'b1;
        @(negedge clk); overflow_clr = 1'b0;
        chk("t3_clr2", {31'b0, overflow}, 0);
        target = k0 + 41;
        while (cyc < target) @(negedge clk);
        chk("t3_pre_full", {31'b0, fifo_full}, 1);
        in_valid = 1'b1; in_data = 8'hC3; exp_q.push_back(8'hC3);
        @(posedge clk); #1;
        chk("t3_simul_count", {29'b0, fifo_count}, 4);
        chk("t3_simul_ovf", {31'b0, overflow}, 0);
        chk("t3_simul_restart", {31'b0, tx}, 0);
        @(negedge clk); in_valid = 1'b0;
        wait_idle("t3");

        // reset during DATA bit 3 with two bytes buffered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) k0 = cyc;
            in_valid = 1'b1; in_data = 8'h00; exp_q.push_back(8'h00);
        end
        @(negedge clk); in_valid = 1'b0;
        target = k0 + 19;
        while (cyc < target) @(negedge clk);
        chk("t4_pre_count", {29'b0, fifo_count}, 2);
        chk("t4_pre_tx", {31'b0, tx}, 0);
        rst_n = 1'b0;
        #1;
        chk("t4_tx", {31'b0, tx}, 1);
        chk("t4_count", {29'b0, fifo_count}, 0);
        chk("t4_busy", {31'b0, busy}, 0);
        exp_q.delete();
        starts.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t4_no_frame", starts.size(), 0);
        chk("t4_idle_tx", {31'b0, tx}, 1);

        // first push after reset release accepted on the first edge
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h5A; exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        chk("t5_first_push", {29'b0, fifo_count}, 1);
        @(negedge clk); in_valid = 1'b0;
        wait_idle("t5");

        // nine bytes spaced 40 cycles: pointers wrap, no overflow
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = nine[i]; exp_q.push_back(nine[i]);
            @(negedge clk); in_valid = 1'b0;
            repeat (38) @(negedge clk);
        end
        wait_idle("t6");
        chk("t6_ovf", {31'b0, overflow}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_uart_tx.md
AXIS_UART_TX -- requirements
Module: axis_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8: data byte width, fixed at 8 for 8N1 framing.
REQ-002 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit; legal range >= 2.
REQ-003 Parameter FIFO_DEPTH, default 4: entries in the input buffer; power of 2, >= 2.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  one-cycle strobe from the upstream AXIS capture stage, which applies no backpressure.
REQ-007 in_data  input  WIDTH  byte qualified by in_valid.
REQ-008 overflow_clr  input  1  synchronous clear of the overflow flag.
REQ-009 tx  output  1  UART serial line, idle high, registered.
REQ-010 busy  output  1  high whenever a frame is in progress (state != IDLE).
REQ-011 fifo_full  output  1  buffer holds FIFO_DEPTH entries.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of buffered bytes.
REQ-013 overflow  output  1  sticky flag: one or more input bytes were dropped.

Function
REQ-014 The buffer SHALL be a circular FIFO with wrapping read and write pointers; it SHALL preserve input byte order.
REQ-015 A push SHALL occur when in_valid=1 and either (fifo_full=0) or a pop occurs in the same cycle.
REQ-016 With in_valid=1, fifo_full=1 and no pop in that cycle, the byte SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL be set on the next edge.
REQ-017 overflow SHALL remain set until overflow_clr=1; if a drop and overflow_clr occur in the same cycle, the drop wins and overflow stays 1.
REQ-018 fifo_count SHALL change by +1 on a push without a pop, by -1 on a pop without a push, and SHALL be unchanged on a simultaneous push and pop.
REQ-019 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1. If fifo_count != 0, the FSM SHALL pop the head byte into the shift register and enter START on the same edge, driving tx=0 from that edge.
REQ-021 START SHALL hold tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-022 DATA SHALL shift out WIDTH bits LSB first, each held for CLKS_PER_BIT cycles, using a bit index of 0..WIDTH-1; after bit WIDTH-1 it SHALL enter STOP.
REQ-023 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles.
REQ-024 At the end of STOP, if fifo_count != 0, the FSM SHALL pop and enter START directly, so back-to-back frames are exactly 10*CLKS_PER_BIT cycles apart; otherwise it SHALL enter IDLE.
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every bit boundary and on every state entry.
REQ-026 Latency: for an in_valid sampled at edge E0 with an empty FIFO and FSM in IDLE, tx SHALL fall at edge E1.
REQ-027 in_data SHALL be sampled only on an accepted push; it SHALL be ignored when in_valid=0.

Reset
REQ-028 While rst_n=0, regardless of clk: tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, and both pointers and all counters = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame: tx returns high immediately and all buffered bytes are discarded.
REQ-030 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 One push of 0x48 while idle -> tx falls one edge after capture; line holds start 0 then bits 0,0,0,1,0,0,1,0, 4 cycles each, then stop 1; busy=1 for exactly 40 cycles.
REQ-032 Push "HELLO\n" on 6 consecutive cycles -> "HELLO" sent back-to-back, each frame 40 cycles with no idle gap; '\n' dropped; overflow=1; fifo_count peaks at 4.
REQ-033 With FIFO full, push on the exact cycle of the STOP-end pop -> push accepted, overflow stays 0, fifo_count stays 4.
REQ-034 overflow=1, then pulse overflow_clr -> overflow=0 next edge; overflow_clr together with a dropped push -> overflow remains 1.
REQ-035 rst_n low during DATA bit 3 with 2 bytes buffered -> tx=1, fifo_count=0, busy=0 immediately; after release, no frame is sent until a new push.
REQ-036 Push 9 bytes spaced 40 cycles apart -> all 9 sent in order; pointers wrap twice; overflow=0.
